dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and the line-wide data memory.
- Produces the stall that freezes the pipeline registers while a miss is serviced.
- Holds the tag, valid and dirty bits and the data arrays internally.
- Answers MEM-stage loads and stores in zero wait states on a hit.

Parameters:
- INDEX_BITS, 5, log2 of the number of lines (32 lines).
- LINE_BITS, 256, line width; the offset width is log2(LINE_BITS/8) = 5.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- p1_req_i  in  1  MEM-stage access valid
- p1_write_i  in  1  1 = store, 0 = load
- p1_addr_i  in  32  byte address, word aligned
- p1_data_i  in  32  store data
- p1_data_o  out  32  load data
- p1_stall_o  out  1  pipeline stall
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = line write-back, 0 = line fetch
- mem_addr_o  out  32  line-aligned address
- mem_data_o  out  LINE_BITS  victim line data
- mem_data_i  in  LINE_BITS  fetched line data
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split: tag = addr[31:5+INDEX_BITS], index = addr[4+INDEX_BITS:5], word = addr[4:2]. addr[1:0] is ignored.
- Reset (synchronous, on the clock edge with rst_i=1):
  - all valid and dirty bits cleared; state=IDLE.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - p1_data_o=0 while no request is present.
  - Data and tag arrays are not cleared.
- hit = p1_req_i & valid[index] & (tag_array[index]==tag).
- p1_stall_o is combinational: (state==IDLE & p1_req_i & ~hit) | (state!=IDLE).
- p1_data_o is combinational: on a read hit it is the selected word of the indexed line; otherwise it is 0.
- Write hit in IDLE: the word is written and dirty[index] is set at that same edge. No stall.
- FSM states:
  - IDLE: on a miss, go to WRITEBACK if valid & dirty, otherwise go to ALLOCATE.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line. On mem_ack_i, go to ALLOCATE.
  - ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={tag, index, 5'b0}. On mem_ack_i, latch mem_data_i and go to FILL.
  - FILL: write the line, set valid, clear dirty, update the tag; go to IDLE. mem_enable_o=0.
  - The access then re-evaluates in IDLE as a hit. A store merges its word and sets dirty at that edge.
- Memory handshake:
  - mem_enable_o and all mem_* outputs stay stable from state entry until the cycle mem_ack_i is sampled high.
  - mem_enable_o drops in the cycle after the ack.
  - mem_ack_i is ignored in IDLE and FILL.
- Miss latency:
  - Clean miss: N+2 stall cycles, where N is the cycles from request to ack inclusive.
  - Dirty miss: adds the write-back latency.
- Boundaries:
  - p1_req_i dropping mid-miss: the fill still completes; no stall afterwards.
  - Reset mid-miss: return to IDLE at once; a late ack is ignored.
  - Same-index, different-tag accesses evict each other. Dirty victims are always written back before the fetch.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count_o[31:0] and miss_count_o[31:0], both cleared by reset.
  - hit_count_o increments once per IDLE-state hit that is not the post-FILL re-evaluation.
  - miss_count_o increments on each IDLE→WRITEBACK or IDLE→ALLOCATE transition.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and the counters are absent.

Test Plan:
- After reset, load 0x0000_0040 with memory returning line L (ack after 10 cycles): ALLOCATE addr 0x40, 12 stall cycles, p1_data_o = L word 0; a following load of 0x44 returns word 1 with no stall.
- Store 0xDEADBEEF to 0x40 (hit), then load 0x0000_0440 (same index 2, different tag): WRITEBACK to 0x40 containing 0xDEADBEEF in word 0, then ALLOCATE 0x440; the total stall equals both latencies + 2.
- Store miss to 0x80 (clean): line fetched, word merged, dirty set; evicting it later triggers a write-back carrying the merged word.
- Spurious mem_ack_i pulses in IDLE: no state change, mem_enable_o remains 0.
- rst_i asserted during ALLOCATE, ack arriving 2 cycles later: mem_enable_o=0 in the cycle after reset, the ack is ignored, and the next load of the same address misses again.
- With DCACHE_STATS_EN: 1 miss plus 3 hits → miss_count_o=1, hit_count_o=3.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_ctrl #(
  parameter int INDEX_BITS = 5,
  parameter int LINE_BITS  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_req_i,
  input  logic                 p1_write_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
`endif
);

  localparam int OFF_W  = 5;
  localparam int TAG_W  = 32 - OFF_W - INDEX_BITS;
  localparam int NLINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_ALLOC,
    S_FILL
  } state_e;

  state_e                state_q, state_d;
  logic [NLINES-1:0]     valid_q, dirty_q;
  logic [TAG_W-1:0]      tag_q  [NLINES];
  logic [LINE_BITS-1:0]  data_q [NLINES];
  logic [LINE_BITS-1:0]  fill_q;
  logic [TAG_W-1:0]      mtag_q, mtag_d;
  logic [INDEX_BITS-1:0] midx_q, midx_d;

  logic [TAG_W-1:0]      tag;
  logic [INDEX_BITS-1:0] idx;
  logic [OFF_W-3:0]      word;
  logic                  hit;
  logic                  wr_hit;
  logic                  unused_addr;

  assign tag  = p1_addr_i[31:OFF_W+INDEX_BITS];
  assign idx  = p1_addr_i[OFF_W+INDEX_BITS-1:OFF_W];
  assign word = p1_addr_i[OFF_W-1:2];
  assign unused_addr = ^p1_addr_i[1:0];

  assign hit    = p1_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign wr_hit = (state_q == S_IDLE) & hit & p1_write_i;

  assign p1_data_o  = (hit & ~p1_write_i) ?
                      data_q[idx][{word, 5'b0} +: 32] : '0;
  assign p1_stall_o = ((state_q == S_IDLE) & p1_req_i & ~hit) |
                      (state_q != S_IDLE);

  // Next state and memory-side outputs; outputs derive only from
  // registered state so they hold steady until the ack.
  always_comb begin
    state_d      = state_q;
    mtag_d       = mtag_q;
    midx_d       = midx_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (p1_req_i && !hit) begin
          mtag_d  = tag;
          midx_d  = idx;
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_ALLOC;
        end
      end
      S_WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[midx_q], midx_q, 5'b0};
        mem_data_o   = data_q[midx_q];
        if (mem_ack_i) state_d = S_ALLOC;
      end
      S_ALLOC: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {mtag_q, midx_q, 5'b0};
        if (mem_ack_i) state_d = S_FILL;
      end
      S_FILL: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, miss address and valid/dirty bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mtag_q  <= '0;
      midx_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      mtag_q  <= mtag_d;
      midx_q  <= midx_d;
      if (state_q == S_FILL) begin
        valid_q[midx_q] <= 1'b1;
        dirty_q[midx_q] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays plus the fill buffer; never cleared.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ALLOC && mem_ack_i) fill_q <= mem_data_i;
    if (state_q == S_FILL) begin
      data_q[midx_q] <= fill_q;
      tag_q[midx_q]  <= mtag_q;
    end else if (wr_hit) begin
      data_q[idx][{word, 5'b0} +: 32] <= p1_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating counters; the hit right after a fill is the miss itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q <= (state_q == S_FILL);
      if (state_q == S_IDLE && hit && !refill_q && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == S_IDLE && p1_req_i && !hit && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule
